rbfu_ntt_sched: RTL

//  Sequences one RBFU_E butterfly through a full in-place Kyber NTT or INTT (q=3329) of
//  an N=256 coefficient polynomial. Issues one butterfly per cycle: coefficient read

---
 rtl/rbfu_ntt_sched.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rbfu_ntt_sched.sv
// Butterfly scheduler for an in-place Kyber NTT/INTT: issues read addresses, twiddle
// index and opcode once per cycle, and returns write-back addresses PIPE cycles later.
module rbfu_ntt_sched #(
  parameter int unsigned LOGN    = 8,
  parameter int unsigned NSTAGE  = 7,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned BFU_LAT = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mode,
  output logic            busy,
  output logic            done,
  output logic [1:0]      opcode,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] zeta_idx,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b,
  output logic [2:0]      stage
);

  localparam int unsigned PIPE = RD_LAT + BFU_LAT;
  localparam int unsigned HALF = 1 << (LOGN - 1);
  localparam int unsigned CW   = LOGN - 1;
  localparam int unsigned DW   = $clog2(PIPE) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic [2:0]      stage_d;
  logic            mode_q, mode_d;

  logic [LOGN-1:0] cnt_ext, len_v, grp_v, off_v, a_v, b_v;
  logic [LOGN-2:0] zeta_v;
  int unsigned     sh;

  logic [PIPE-1:0] wv_q;
  logic [LOGN-1:0] wa_q [PIPE];
  logic [LOGN-1:0] wb_q [PIPE];

  // Next-state logic; counters advance so the registered outputs describe the next cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    stage_d = stage;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          stage_d = 3'd0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == CW'(HALF - 1)) begin
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DW'(PIPE - 1)) begin
          if (stage == 3'(NSTAGE - 1)) begin
            state_d = S_DONE;
          end else begin
            stage_d = stage + 3'd1;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address and twiddle generation for the butterfly issued next cycle
  always_comb begin
    cnt_ext = LOGN'(cnt_d);
    sh      = mode_d ? (32'(stage_d) + 1) : ((LOGN - 1) - 32'(stage_d));
    len_v   = LOGN'(1) << sh;
    grp_v   = cnt_ext >> sh;
    off_v   = cnt_ext & (len_v - LOGN'(1));
    a_v     = (grp_v << (sh + 1)) | off_v;
    b_v     = a_v + len_v;
    if (mode_d) zeta_v = (LOGN-1)'((LOGN'(HALF) >> stage_d) - LOGN'(1) - grp_v);
    else        zeta_v = (LOGN-1)'((LOGN'(1) << stage_d) + grp_v);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      stage     <= 3'd0;
      mode_q    <= 1'b0;
      opcode    <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      zeta_idx  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      stage   <= stage_d;
      mode_q  <= mode_d;
      if (state_q == S_IDLE && start) opcode <= {1'b0, mode};
      busy  <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done  <= (state_d == S_DONE);
      rd_en <= (state_d == S_RUN);
      if (state_d == S_RUN) begin
        rd_addr_a <= a_v;
        rd_addr_b <= b_v;
        zeta_idx  <= zeta_v;
      end
    end
  end

  // Write-back delay line; tail entry drives the write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      wv_q <= '0;
      for (int i = 0; i < PIPE; i++) begin
        wa_q[i] <= '0;
        wb_q[i] <= '0;
      end
    end else begin
      wv_q[0] <= rd_en;
      wa_q[0] <= rd_addr_a;
      wb_q[0] <= rd_addr_b;
      for (int i = 1; i < PIPE; i++) begin
        wv_q[i] <= wv_q[i-1];
        wa_q[i] <= wa_q[i-1];
        wb_q[i] <= wb_q[i-1];
      end
    end
  end

  assign wr_en     = wv_q[PIPE-1];
  assign wr_addr_a = wa_q[PIPE-1];
  assign wr_addr_b = wb_q[PIPE-1];

endmodule
